// File: rtl/box_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | box_sequencer: pseudo-random left/right box stream with a lookahead queue, |
// | boxes-remaining counter and sticky finish flag, one instance per player.   |
// | Optional macro: BOX_SEQ_NO_REPEAT3_EN (never three equal boxes in a row).  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module box_sequencer #(
  parameter int         DEPTH       = 4,
  parameter int         TOTAL_BOXES = 30,
  parameter logic [7:0] SEED        = 8'hA5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             advance,
  input  logic             abort,
  output logic             correct_box,
  output logic [DEPTH-1:0] lookahead,
  output logic [6:0]       boxes_left,
  output logic             valid,
  output logic             finish
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] FILL = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [6:0] C_TOTAL    = 7'(TOTAL_BOXES);
  localparam logic [3:0] C_FILL_END = 4'(DEPTH - 1);
  localparam logic [7:0] C_MASK     = 8'hB8;

  logic [1:0]       state_q, state_d;
  logic [7:0]       lfsr_q, lfsr_d;
  logic [DEPTH-1:0] lookahead_q, lookahead_d;
  logic [6:0]       boxes_left_q, boxes_left_d;
  logic             valid_q, valid_d;
  logic             finish_q, finish_d;
  logic [3:0]       fill_q, fill_d;

  logic [7:0]       lfsr_next;
  logic             gen;
  logic             new_bit;
  logic             restart_hist;

  assign lfsr_next = lfsr_q[0] ? ((lfsr_q >> 1) ^ C_MASK) : (lfsr_q >> 1);

`ifdef BOX_SEQ_NO_REPEAT3_EN
  // History holds the last two inserted boxes; cnt saturates at 2 once both are meaningful.
  logic [1:0] hist_q, hist_d;
  logic [1:0] hist_cnt_q, hist_cnt_d;

  always_comb begin
    new_bit = lfsr_q[0];
    if ((hist_cnt_q == 2'd2) && (hist_q[0] == hist_q[1]) && (lfsr_q[0] == hist_q[0])) begin
      new_bit = ~lfsr_q[0];
    end
    hist_d     = hist_q;
    hist_cnt_d = hist_cnt_q;
    if (restart_hist) begin
      hist_cnt_d = 2'd0;
    end else if (gen) begin
      hist_d = {hist_q[0], new_bit};
      if (hist_cnt_q != 2'd2) begin
        hist_cnt_d = hist_cnt_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hist_q     <= 2'b00;
      hist_cnt_q <= 2'd0;
    end else begin
      hist_q     <= hist_d;
      hist_cnt_q <= hist_cnt_d;
    end
  end
`else
  always_comb begin
    new_bit = lfsr_q[0];
  end
`endif

  always_comb begin
    state_d      = state_q;
    lfsr_d       = lfsr_q;
    lookahead_d  = lookahead_q;
    boxes_left_d = boxes_left_q;
    valid_d      = valid_q;
    finish_d     = finish_q;
    fill_d       = fill_q;
    gen          = 1'b0;
    restart_hist = 1'b0;

    case (state_q)
      IDLE: begin
        // Free-running LFSR here lets player timing seed the game.
        lfsr_d  = lfsr_next;
        valid_d = 1'b0;
        if (start) begin
          state_d      = FILL;
          fill_d       = 4'd0;
          restart_hist = 1'b1;
        end
      end
      FILL: begin
        if (abort) begin
          state_d = DONE;
        end else begin
          gen    = 1'b1;
          fill_d = fill_q + 4'd1;
          if (fill_q == C_FILL_END) begin
            state_d = RUN;
            valid_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (abort) begin
          state_d = DONE;
          valid_d = 1'b0;
        end else if (!start) begin
          state_d      = IDLE;
          valid_d      = 1'b0;
          boxes_left_d = C_TOTAL;
        end else if (advance) begin
          if (boxes_left_q == 7'd1) begin
            boxes_left_d = 7'd0;
            finish_d     = 1'b1;
            valid_d      = 1'b0;
            state_d      = DONE;
          end else begin
            gen          = 1'b1;
            boxes_left_d = boxes_left_q - 7'd1;
          end
        end
      end
      DONE: begin
        if (!start) begin
          state_d      = IDLE;
          boxes_left_d = C_TOTAL;
          finish_d     = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (gen) begin
      lfsr_d      = lfsr_next;
      lookahead_d = {new_bit, lookahead_q[DEPTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      lfsr_q       <= SEED;
      lookahead_q  <= '0;
      boxes_left_q <= C_TOTAL;
      valid_q      <= 1'b0;
      finish_q     <= 1'b0;
      fill_q       <= 4'd0;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      lookahead_q  <= lookahead_d;
      boxes_left_q <= boxes_left_d;
      valid_q      <= valid_d;
      finish_q     <= finish_d;
      fill_q       <= fill_d;
    end
  end

  assign correct_box = lookahead_q[0];
  assign lookahead   = lookahead_q;
  assign boxes_left  = boxes_left_q;
  assign valid       = valid_q;
  assign finish      = finish_q;

endmodule
`default_nettype wire

// File: tb/tb_box_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_box_sequencer: scoreboard bench with a stream-level reference model.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_box_sequencer;

  localparam int         DEPTH       = 4;
  localparam int         TOTAL_BOXES = 30;
  localparam logic [7:0] SEED        = 8'hA5;

  localparam int P_IDLE = 0;
  localparam int P_FILL = 1;
  localparam int P_RUN  = 2;
  localparam int P_DONE = 3;

  logic             clk = 1'b0;
  logic             reset, start, advance, abort;
  logic             correct_box;
  logic [DEPTH-1:0] lookahead;
  logic [6:0]       boxes_left;
  logic             valid, finish;

  box_sequencer #(
    .DEPTH      (DEPTH),
    .TOTAL_BOXES(TOTAL_BOXES),
    .SEED       (SEED)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .advance    (advance),
    .abort      (abort),
    .correct_box(correct_box),
    .lookahead  (lookahead),
    .boxes_left (boxes_left),
    .valid      (valid),
    .finish     (finish)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DEPTH-1:0] la;
    logic [6:0]       left;
    logic             valid;
    logic             finish;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: game phase, LFSR value, box queue (index 0 = current).
  int         m_phase;
  logic [7:0] m_lfsr;
  bit         m_q[$];
  bit         m_hist[$];
  int         m_left;
  bit         m_valid, m_finish;
  int         m_fill;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return v[0] ? ((v >> 1) ^ 8'hB8) : (v >> 1);
  endfunction

  function automatic logic [DEPTH-1:0] q_vec();
    logic [DEPTH-1:0] v;
    for (int i = 0; i < DEPTH; i++) v[i] = m_q[i];
    return v;
  endfunction

  task automatic push_box();
    bit b;
    b = m_lfsr[0];
`ifdef BOX_SEQ_NO_REPEAT3_EN
    if (m_hist.size() >= 2 && m_hist[$] == b && m_hist[$-1] == b) b = ~b;
    m_hist.push_back(b);
    if (m_hist.size() > 2) void'(m_hist.pop_front());
`endif
    m_lfsr = lfsr_next(m_lfsr);
    void'(m_q.pop_front());
    m_q.push_back(b);
  endtask

  task automatic model(input bit r, input bit s, input bit a, input bit ab);
    if (r) begin
      m_phase = P_IDLE; m_lfsr = SEED; m_left = TOTAL_BOXES;
      m_valid = 0; m_finish = 0; m_fill = 0;
      m_q.delete(); m_hist.delete();
      for (int i = 0; i < DEPTH; i++) m_q.push_back(1'b0);
    end else begin
      case (m_phase)
        P_IDLE: begin
          m_lfsr = lfsr_next(m_lfsr);
          if (s) begin m_phase = P_FILL; m_fill = 0; m_hist.delete(); end
        end
        P_FILL: begin
          if (ab) m_phase = P_DONE;
          else begin
            push_box();
            m_fill++;
            if (m_fill == DEPTH) begin m_phase = P_RUN; m_valid = 1; end
          end
        end
        P_RUN: begin
          if (ab) begin m_phase = P_DONE; m_valid = 0; end
          else if (!s) begin m_phase = P_IDLE; m_valid = 0; m_left = TOTAL_BOXES; end
          else if (a) begin
            if (m_left == 1) begin
              m_left = 0; m_finish = 1; m_valid = 0; m_phase = P_DONE;
            end else begin
              push_box();
              m_left--;
            end
          end
        end
        default: begin
          if (!s) begin m_phase = P_IDLE; m_left = TOTAL_BOXES; m_finish = 0; end
        end
      endcase
    end
  endtask

  task automatic step(input bit r, input bit s, input bit a, input bit ab);
    exp_t e;
    reset = r; start = s; advance = a; abort = ab;
    model(r, s, a, ab);
    @(posedge clk);
    e.la = q_vec(); e.left = 7'(m_left); e.valid = m_valid; e.finish = m_finish;
    sb.push_back(e);
    #1;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("lookahead", 32'(lookahead), 32'(e.la));
      chk("correct_box", 32'(correct_box), 32'(e.la[0]));
      chk("boxes_left", 32'(boxes_left), 32'(e.left));
      chk("valid", 32'(valid), 32'(e.valid));
      chk("finish", 32'(finish), 32'(e.finish));
`ifdef BOX_SEQ_NO_REPEAT3_EN
      if (valid) begin
        for (int i = 0; i + 2 < DEPTH; i++) begin
          chk("no_repeat3", 32'((lookahead[i] == lookahead[i+1]) && (lookahead[i+1] == lookahead[i+2])), 32'd0);
        end
      end
`endif
    end
  end

  initial begin
    int saved_left;
    reset = 1; start = 0; advance = 0; abort = 0;
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("reset_left", 32'(boxes_left), 32'd30);
    chk("reset_valid", 32'(valid), 32'd0);

    // Start right after reset: valid rises exactly DEPTH+1 edges later.
    for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 0);
    chk("valid_early", 32'(valid), 32'd0);
    step(0, 1, 0, 0);
    chk("first_la", 32'(lookahead), 32'hA);
    chk("first_valid", 32'(valid), 32'd1);

    step(0, 1, 1, 0);
    chk("adv_la", 32'(lookahead), 32'h5);
    chk("adv_left", 32'(boxes_left), 32'd29);
    repeat (10) step(0, 1, 0, 0);
    chk("hold_la", 32'(lookahead), 32'h5);

    // Play to the top with random gaps, then poke at the finished state.
    while (m_left > 0 && m_phase == P_RUN) begin
      step(0, 1, ($urandom_range(0, 2) != 0), 0);
    end
    chk("fin_finish", 32'(finish), 32'd1);
    chk("fin_left", 32'(boxes_left), 32'd0);
    step(0, 1, 1, 0);
    step(0, 1, 0, 1);
    chk("fin_hold", 32'(boxes_left), 32'd0);
    step(0, 0, 0, 0);
    chk("restart_left", 32'(boxes_left), 32'd30);
    chk("restart_finish", 32'(finish), 32'd0);

    // Abort together with advance while running.
    repeat (DEPTH + 1) step(0, 1, 0, 0);
    step(0, 1, 1, 0);
    step(0, 1, 1, 0);
    saved_left = int'(boxes_left);
    step(0, 1, 1, 1);
    chk("abort_valid", 32'(valid), 32'd0);
    chk("abort_left", 32'(boxes_left), 32'(saved_left));
    repeat (3) step(0, 1, 1, 0);
    chk("abort_ignore", 32'(boxes_left), 32'(saved_left));
    step(0, 0, 0, 0);

    // Reset mid-run at 17 boxes left, then replay the opening.
    repeat (DEPTH + 1) step(0, 1, 0, 0);
    while (m_left > 17) step(0, 1, 1, 0);
    chk("pre_reset_left", 32'(boxes_left), 32'd17);
    step(1, 1, 1, 0);
    chk("mid_reset_la", 32'(lookahead), 32'd0);
    chk("mid_reset_left", 32'(boxes_left), 32'd30);
    chk("mid_reset_valid", 32'(valid), 32'd0);
    repeat (DEPTH + 1) step(0, 1, 0, 0);
    chk("replay_la", 32'(lookahead), 32'hA);

    // Randomized play across all inputs.
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 39) != 0),
           ($urandom_range(0, 9) < 4),
           ($urandom_range(0, 99) < 2));
    end
    step(0, 0, 0, 0);

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
